// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants and types for the 1-to-2 stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] beat_t;

  // Destination channel encoding carried by in_sel
  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

endpackage

`default_nettype wire

// File: rtl/stream_demux_slot.sv
// ============================================================================
// Module      : stream_demux_slot
// Description : One-entry holding register for a single output channel.
//               Push and pop in the same cycle keep the slot full and load
//               the new beat, so a streaming consumer sees no bubble.
//               With STREAM_DEMUX_CNT_EN defined, a saturating counter of
//               delivered (popped) beats is added.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              rdy
`ifdef STREAM_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  logic pop;

  // A pop happens only when the slot actually holds a beat
  assign pop = full & pop_ready;
  // The slot can take a beat if empty or if it is being drained this cycle
  assign rdy = ~full | pop_ready;

  // Slot occupancy and payload; data keeps its value while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  // Delivered-beat counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pop && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/stream_demux_1x2.sv
// ============================================================================
// Module      : stream_demux_1x2
// Description : Registered 1-to-2 stream demultiplexer. Each input beat is
//               steered by in_sel into one of two independent one-entry
//               channel slots; each channel backpressures on its own.
//               Optional feature macro: STREAM_DEMUX_CNT_EN adds per-channel
//               saturating delivered-beat counters (cnt0/cnt1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1x2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready
`ifdef STREAM_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  chan_e sel;
  logic  rdy0;
  logic  rdy1;
  logic  push0;
  logic  push1;

  assign sel = chan_e'(in_sel);

  // Ready reflects only the selected channel; never gated by in_valid
  assign in_ready = (sel == CH1) ? rdy1 : rdy0;

  // Push decode: an accepted beat goes to exactly one channel
  assign push0 = in_valid & in_ready & (sel == CH0);
  assign push1 = in_valid & in_ready & (sel == CH1);

  stream_demux_slot #(
    .DATA_W (DATA_W)
`ifdef STREAM_DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop_ready (out0_ready),
    .full      (out0_valid),
    .data      (out0_data),
    .rdy       (rdy0)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt     (cnt0)
`endif
  );

  stream_demux_slot #(
    .DATA_W (DATA_W)
`ifdef STREAM_DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop_ready (out1_ready),
    .full      (out1_valid),
    .data      (out1_data),
    .rdy       (rdy1)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt     (cnt1)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1x2.sv
// ============================================================================
// Module      : tb_stream_demux_1x2
// Description : Self-checking bench for stream_demux_1x2. A queue-per-channel
//               reference model (at most one beat per queue) predicts
//               in_ready, valid, data and delivered-beat counts.
//               Counter checks only exist when STREAM_DEMUX_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stream_demux_1x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out0_data;
  logic [7:0] out1_data;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        s_in_ready;
  logic [7:0]  s_out0_data;
  logic [7:0]  s_out1_data;
  logic        s_out0_valid;
  logic        s_out1_valid;
  logic [2:0]  s_cnt0;
  logic [2:0]  s_cnt1;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: pending beat per channel and delivered-beat totals
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int c0 = 0;
  int c1 = 0;

  always #5 clk = ~clk;

  stream_demux_1x2 #(
    .DATA_W (8)
`ifdef STREAM_DEMUX_CNT_EN
    , .CNT_W (16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt0     (cnt0)
    , .cnt1     (cnt1)
`endif
  );

`ifdef STREAM_DEMUX_CNT_EN
  // Narrow-counter copy sharing all inputs, used for saturation checks
  stream_demux_1x2 #(
    .DATA_W (8),
    .CNT_W  (3)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .out0_data  (s_out0_data),
    .out0_valid (s_out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (s_out1_data),
    .out1_valid (s_out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (s_cnt0),
    .cnt1       (s_cnt1)
  );
`endif

  function automatic bit exp_ready(input bit sel);
    if (sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  task automatic drive(input bit v, input bit s, input logic [7:0] d,
                       input bit r0, input bit r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
  endtask

  // Advance one clock edge and apply the channel rules to the model
  task automatic edge_step();
    bit acc, p0, p1;
    @(posedge clk);
    if (!rst_n) begin
      q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    end else begin
      acc = in_valid && exp_ready(in_sel);
      p0  = (q0.size() > 0) && out0_ready;
      p1  = (q1.size() > 0) && out1_ready;
      if (p0) begin void'(q0.pop_front()); c0++; end
      if (p1) begin void'(q1.pop_front()); c1++; end
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
        bad++; $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid);
      end
      total++;
      if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
        bad++; $display("FAIL reset_data: got %h/%h want 00/00", out0_data, out1_data);
      end
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready: sel=%b got %b want 1", in_sel, in_ready);
      end
`ifdef STREAM_DEMUX_CNT_EN
      total++;
      if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
        bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
      end
`endif
      edge_step();
    end
    drive(0, 1, 8'h00, 0, 0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready_sel1: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1, 0, 8'hA5, 1, 0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_in_ready: got %b want 1", in_ready);
    end
    edge_step();
    drive(0, 0, 8'h00, 1, 0);
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
      bad++; $display("FAIL single_out0: got v=%b d=%h want v=1 d=a5", out0_valid, out0_data);
    end
    total++;
    if (out1_valid !== 1'b0) begin
      bad++; $display("FAIL single_out1_quiet: got %b want 0", out1_valid);
    end
    edge_step();
    total++;
    if (out0_valid !== 1'b0) begin
      bad++; $display("FAIL single_one_cycle: got %b want 0", out0_valid);
    end
`ifdef STREAM_DEMUX_CNT_EN
    total++;
    if (cnt0 !== 16'd1) begin
      bad++; $display("FAIL single_cnt0: got %0d want 1", cnt0);
    end
`endif
  endtask

  task automatic test_streaming();
    logic [7:0] d, prev;
    prev = 8'h00;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      drive(1, 1, d, 0, 1);
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_in_ready: beat %0d got %b want 1", i, in_ready);
      end
      if (i > 0) begin
        total++;
        if (out1_valid !== 1'b1 || out1_data !== prev) begin
          bad++; $display("FAIL stream_order: beat %0d got v=%b d=%h want v=1 d=%h", i - 1, out1_valid, out1_data, prev);
        end
      end
      edge_step();
      prev = d;
    end
    drive(0, 0, 8'h00, 0, 1);
    total++;
    if (out1_valid !== 1'b1 || out1_data !== prev) begin
      bad++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=%h", out1_valid, out1_data, prev);
    end
    edge_step();
    total++;
    if (out1_valid !== 1'b0) begin
      bad++; $display("FAIL stream_drained: got %b want 0", out1_valid);
    end
`ifdef STREAM_DEMUX_CNT_EN
    total++;
    if (cnt1 !== 16'd10) begin
      bad++; $display("FAIL stream_cnt1: got %0d want 10", cnt1);
    end
`endif
  endtask

  task automatic test_backpressure();
    drive(1, 0, 8'h3C, 0, 0);
    edge_step();
    drive(1, 0, 8'h55, 0, 0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_blocked: got %b want 0", in_ready);
    end
    edge_step();
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h3C) begin
      bad++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=3c", out0_valid, out0_data);
    end
    drive(1, 1, 8'hC3, 0, 0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_other_ready: got %b want 1", in_ready);
    end
    edge_step();
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 8'hC3 || out0_data !== 8'h3C) begin
      bad++; $display("FAIL bp_isolation: got out1 v=%b d=%h out0 d=%h want 1 c3 3c", out1_valid, out1_data, out0_data);
    end
  endtask

  task automatic test_pop_push();
    // Replace 3C with 11 while also draining C3 from channel 1
    drive(1, 0, 8'h11, 1, 1);
    edge_step();
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h11 || out1_valid !== 1'b0) begin
      bad++; $display("FAIL pp_setup: got v0=%b d0=%h v1=%b want 1 11 0", out0_valid, out0_data, out1_valid);
    end
    drive(1, 0, 8'h22, 1, 0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL pp_in_ready: got %b want 1", in_ready);
    end
    edge_step();
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
      bad++; $display("FAIL pp_no_bubble: got v=%b d=%h want v=1 d=22", out0_valid, out0_data);
    end
`ifdef STREAM_DEMUX_CNT_EN
    total++;
    if (cnt0 !== 16'd3) begin
      bad++; $display("FAIL pp_cnt0: got %0d want 3", cnt0);
    end
`endif
    drive(0, 0, 8'h00, 1, 1);
    edge_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      total++;
      if (in_ready !== exp_ready(in_sel)) begin
        bad++; $display("FAIL rnd_in_ready: cyc %0d got %b want %b", i, in_ready, exp_ready(in_sel));
      end
      total++;
      if (out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)) begin
        bad++; $display("FAIL rnd_valid: cyc %0d got %b/%b want %b/%b", i, out0_valid, out1_valid, q0.size() > 0, q1.size() > 0);
      end
      if (q0.size() > 0) begin
        total++;
        if (out0_data !== q0[0]) begin
          bad++; $display("FAIL rnd_data0: cyc %0d got %h want %h", i, out0_data, q0[0]);
        end
      end
      if (q1.size() > 0) begin
        total++;
        if (out1_data !== q1[0]) begin
          bad++; $display("FAIL rnd_data1: cyc %0d got %h want %h", i, out1_data, q1[0]);
        end
      end
`ifdef STREAM_DEMUX_CNT_EN
      total++;
      if (cnt0 !== 16'(c0) || cnt1 !== 16'(c1)) begin
        bad++; $display("FAIL rnd_cnt: cyc %0d got %0d/%0d want %0d/%0d", i, cnt0, cnt1, c0, c1);
      end
`endif
      edge_step();
    end
  endtask

  task automatic test_saturation_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    edge_step();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 8'($urandom), 0, 1);
      edge_step();
    end
    drive(0, 0, 8'h00, 0, 1);
    edge_step();
`ifdef STREAM_DEMUX_CNT_EN
    total++;
    if (cnt1 !== 16'd9) begin
      bad++; $display("FAIL sat_wide_cnt1: got %0d want 9", cnt1);
    end
    total++;
    if (s_cnt1 !== 3'd7) begin
      bad++; $display("FAIL sat_narrow_cnt1: got %0d want 7", s_cnt1);
    end
`endif
    drive(1, 1, 8'h77, 0, 0);
    edge_step();
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin
      bad++; $display("FAIL rst_pre_full: got v=%b d=%h want v=1 d=77", out1_valid, out1_data);
    end
    // Assert reset between clock edges; outputs must clear without an edge
    rst_n = 1'b0;
    q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    drive(0, 0, 8'h00, 0, 0);
    total++;
    if (out1_valid !== 1'b0 || out1_data !== 8'h00) begin
      bad++; $display("FAIL rst_async: got v=%b d=%h want v=0 d=00", out1_valid, out1_data);
    end
`ifdef STREAM_DEMUX_CNT_EN
    total++;
    if (cnt1 !== 16'd0 || s_cnt1 !== 3'd0) begin
      bad++; $display("FAIL rst_async_cnt: got %0d/%0d want 0/0", cnt1, s_cnt1);
    end
`endif
    edge_step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 1, 1);
      total++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
        bad++; $display("FAIL rst_no_ghost: cyc %0d got %b/%b want 0/0", i, out0_valid, out1_valid);
      end
      edge_step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_pop_push();
    test_random();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
